// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding simple_cpu: writable instruction memory, program
// counter and a FETCH/ISSUE/WAIT handshake that stops on a HALT sentinel word.
module instr_fetch_unit #(
    parameter int unsigned                INSTR_WIDTH = 20,
    parameter int unsigned                PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0]     HALT_WORD   = 20'hFFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   cpu_done,
    input  logic                   jump_en,
    input  logic [PC_BITS-1:0]     jump_addr,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] fetch_q, fetch_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   mem_we;

    logic [INSTR_WIDTH-1:0] mem_q [2**PC_BITS];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch_d = fetch_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        mem_we  = prog_we && (state_q == S_IDLE || state_q == S_HALT);
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                fetch_d = mem_q[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // The sentinel is never issued; pc is left pointing at it.
                if (fetch_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else begin
                    instr_d = fetch_q;
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_done) begin
                    pc_d    = jump_en ? jump_addr : pc_q + PC_BITS'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            fetch_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fetch_q <= fetch_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Program memory survives reset, so it lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a program-level model
// (memory array plus expected pc sequence).
module tb_instr_fetch_unit;

    localparam int          DEPTH = 32;
    localparam logic [19:0] HALTW = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        cpu_done;
    logic        jump_en;
    logic [4:0]  jump_addr;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [19:0] ref_mem [DEPTH];
    int          ref_pc;
    logic [19:0] last_instr;

    instr_fetch_unit #(.INSTR_WIDTH(20), .PC_BITS(5), .HALT_WORD(20'hFFFFF)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .cpu_done(cpu_done),
        .jump_en(jump_en), .jump_addr(jump_addr), .instruction(instruction),
        .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] rand_word();
        logic [19:0] w;
        do w = 20'($urandom); while (w == HALTW);
        return w;
    endfunction

    task automatic load(input int a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = 5'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        ref_mem[a] = d;
    endtask

    // Called just after the edge that entered FETCH; ends after the issue edge.
    task automatic expect_issue();
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_valid", 32'(instr_valid), 32'd0);
        check("fetch_pc", 32'(pc), 32'(ref_pc));
        tick();
        check("issue_valid", 32'(instr_valid), 32'd0);
        check("issue_instr_hold", 32'(instruction), 32'(last_instr));
        tick();
        if (ref_mem[ref_pc] == HALTW) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_busy", 32'(busy), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_pc", 32'(pc), 32'(ref_pc));
            check("halt_instr", 32'(instruction), 32'(last_instr));
        end else begin
            check("issue_pulse", 32'(instr_valid), 32'd1);
            check("issue_instr", 32'(instruction), 32'(ref_mem[ref_pc]));
            check("issue_pc", 32'(pc), 32'(ref_pc));
            check("issue_halted", 32'(halted), 32'd0);
            last_instr = ref_mem[ref_pc];
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        ref_pc = 0;
        check("start_halted", 32'(halted), 32'd0);
        expect_issue();
    endtask

    // Idle cycles in WAIT; with noise, inputs that must be ignored are toggled.
    task automatic wait_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                jump_en   = 1'($urandom_range(0, 1));
                jump_addr = 5'($urandom_range(0, 31));
                start     = 1'($urandom_range(0, 1));
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = 5'($urandom_range(0, 31));
                prog_data = 20'($urandom);
            end
            tick();
            check("wait_valid", 32'(instr_valid), 32'd0);
            check("wait_instr", 32'(instruction), 32'(last_instr));
            check("wait_pc", 32'(pc), 32'(ref_pc));
            check("wait_busy", 32'(busy), 32'd1);
        end
        jump_en = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic retire(input bit jmp, input logic [4:0] tgt);
        cpu_done  = 1'b1;
        jump_en   = jmp;
        jump_addr = tgt;
        tick();
        cpu_done = 1'b0;
        jump_en  = 1'b0;
        check("done_valid", 32'(instr_valid), 32'd0);
        check("done_instr_hold", 32'(instruction), 32'(last_instr));
        ref_pc = jmp ? int'(tgt) : (ref_pc + 1) % DEPTH;
        expect_issue();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, 32'(instruction), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [19:0] w;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; cpu_done = 1'b0; jump_en = 1'b0; jump_addr = '0;
        last_instr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic program ending in HALT.
        load(0, 20'h47000);
        load(1, 20'h53000);
        load(2, 20'hFFFFF);
        do_start();
        retire(1'b0, 5'd0);
        retire(1'b0, 5'd0);

        // Load while halted, restart, hold in WAIT, then jump.
        load(3, 20'h72001);
        load(4, 20'hFFFFF);
        do_start();
        wait_cycles(10, 1'b0);
        retire(1'b1, 5'd3);
        retire(1'b0, 5'd0);

        // Fill memory with non-HALT words and walk through the pc wrap.
        for (int i = 0; i < DEPTH; i++) load(i, rand_word());
        do_start();
        w = ~ref_mem[1];
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = w;
        tick();
        prog_we = 1'b0;
        check("we_in_wait_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            wait_cycles($urandom_range(0, 3), 1'b1);
            retire(1'b0, 5'd0);
        end
        check("wrap_pc", 32'(pc), 32'd0);

        // Random mix of sequential advances and jumps.
        for (int i = 0; i < 24; i++) begin
            wait_cycles($urandom_range(0, 2), 1'b1);
            retire($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset mid-WAIT, then memory retention.
        wait_cycles(1, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        last_instr = '0;
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        do_start();
        retire(1'b0, 5'd0);

        // Write and start in the same cycle from IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_instr = '0;
        tick();
        w = rand_word();
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = w; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        ref_mem[0] = w;
        ref_pc = 0;
        expect_issue();
        retire(1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
